i2c_target: RTL and testbench

//  I2C target (slave) responder: the bus-side counterpart of the I2C master/controller.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_filter.sv | 53 +++++
 rtl/i2c_target.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM encoding, bus-level ACK/NACK values
// and the default BH1750 target address.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] BH1750_ADDR = 7'h23;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one open-drain bus line: 2-flop synchronizer followed by a
// debounce that only accepts a new level after FILT_LEN consecutive equal
// samples. Input-to-level latency is 2+FILT_LEN cycles.
// Ports:
//   clk, reset : system clock, async active-high reset (line idles high)
//   din        : raw pad level
//   level      : filtered level
//   rise, fall : 1-cycle strobes coincident with a filtered level change
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the current level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target emulating a BH1750-style light sensor. Standard mode, never
// stretches SCL. Written bytes are delivered as commands; reads return a
// snapshot of rd_data, MSB byte first, padded with 8'hFF.
// Ports:
//   clk, reset        : system clock, async active-high reset
//   sda_in, scl_in    : pad levels
//   sda_out, sda_dir  : open-drain SDA drive (sda_dir=1 pulls low)
//   rd_data           : read payload, captured when a read address is ACKed
//   cmd_data/cmd_valid: last written byte and its 1-cycle update strobe
//   rd_latch          : 1-cycle strobe when rd_data is captured
//   busy              : addressed transfer in progress
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR     = BH1750_ADDR,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned RD_BYTES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sda_in,
  output logic                  sda_out,
  output logic                  sda_dir,
  input  logic                  scl_in,
  input  logic [RD_BYTES*8-1:0] rd_data,
  output logic [7:0]            cmd_data,
  output logic                  cmd_valid,
  output logic                  rd_latch,
  output logic                  busy
);

  localparam int unsigned RD_W = RD_BYTES * 8;
  localparam int unsigned IW   = $clog2(RD_BYTES + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk   (clk),
    .reset (reset),
    .din   (scl_in),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk   (clk),
    .reset (reset),
    .din   (sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_state_t      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            byte_full;
  logic            rw;
  logic [IW-1:0]   byte_idx;
  logic [RD_W-1:0] snapshot;
  logic [7:0]      tx;

  logic       start_det;
  logic       stop_det;
  logic [7:0] cur_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  // Byte to transmit for the current byte_idx; past the payload reads as 8'hFF
  always_comb begin
    cur_byte = 8'hFF;
    for (int unsigned k = 0; k < RD_BYTES; k++) begin
      if (byte_idx == IW'(k)) cur_byte = snapshot[(RD_BYTES-1-k)*8 +: 8];
    end
  end

  // Protocol FSM; sda_out always tracks ~sda_dir so a driven SDA is always low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      byte_full <= 1'b0;
      rw        <= 1'b0;
      byte_idx  <= '0;
      snapshot  <= '0;
      tx        <= '0;
      sda_dir   <= 1'b0;
      sda_out   <= 1'b1;
      cmd_data  <= 8'h00;
      cmd_valid <= 1'b0;
      rd_latch  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      rd_latch  <= 1'b0;
      if (start_det) begin
        state     <= ST_ADDR;
        sda_dir   <= 1'b0;
        sda_out   <= 1'b1;
        bit_cnt   <= '0;
        byte_full <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        sda_dir   <= 1'b0;
        sda_out   <= 1'b1;
        byte_full <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;

          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_full <= 1'b1;
            end else if (scl_fall && byte_full) begin
              byte_full <= 1'b0;
              if (shift[7:1] == ADDR) begin
                sda_dir <= 1'b1;
                sda_out <= 1'b0;
                busy    <= 1'b1;
                rw      <= shift[0];
                state   <= ST_ADDR_ACK;
                if (shift[0]) begin
                  snapshot <= rd_data;
                  rd_latch <= 1'b1;
                  byte_idx <= '0;
                end
              end else begin
                state <= ST_IGNORE;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (rw) begin
                state   <= ST_RD_DATA;
                tx      <= cur_byte;
                sda_dir <= ~cur_byte[7];
                sda_out <= cur_byte[7];
              end else begin
                state     <= ST_WR_DATA;
                sda_dir   <= 1'b0;
                sda_out   <= 1'b1;
                byte_full <= 1'b0;
              end
            end
          end

          ST_WR_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_full <= 1'b1;
            end else if (scl_fall && byte_full) begin
              byte_full <= 1'b0;
              cmd_data  <= shift;
              cmd_valid <= 1'b1;
              sda_dir   <= 1'b1;
              sda_out   <= 1'b0;
              state     <= ST_WR_ACK;
            end
          end

          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_dir <= 1'b0;
              sda_out <= 1'b1;
              bit_cnt <= '0;
              state   <= ST_WR_DATA;
            end
          end

          // tx[7] is already on the line; each fall moves to the next bit
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_dir <= 1'b0;
                sda_out <= 1'b1;
                bit_cnt <= '0;
                state   <= ST_RD_ACK;
              end else begin
                sda_dir <= ~tx[6];
                sda_out <= tx[6];
                tx      <= {tx[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == ACK) begin
                if (byte_idx != IW'(RD_BYTES)) byte_idx <= byte_idx + IW'(1);
              end else begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end
            end else if (scl_fall) begin
              state   <= ST_RD_DATA;
              tx      <= cur_byte;
              sda_dir <= ~cur_byte[7];
              sda_out <= cur_byte[7];
            end
          end

          ST_IGNORE: ;

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a bus-master model drives SCL/SDA, pushes
// expected DUT events into queues, and a monitor pops and compares them.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int unsigned Q        = 10;
  localparam int unsigned FILT_LEN = 4;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        sda_m   = 1'b1;
  logic        scl_m   = 1'b1;
  logic [15:0] rd_data = 16'h1234;
  logic        sda_line;
  logic        sda_out, sda_dir, cmd_valid, rd_latch, busy;
  logic [7:0]  cmd_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_cmd[$];
  bit         exp_latch[$];
  logic [8:0] exp_rx[$];   // bit8=1: ack slot value in bit0; bit8=0: read byte
  logic [8:0] obs_rx[$];

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~(sda_dir & ~sda_out);

  i2c_target dut (
    .clk       (clk),
    .reset     (reset),
    .sda_in    (sda_line),
    .sda_out   (sda_out),
    .sda_dir   (sda_dir),
    .scl_in    (scl_m),
    .rd_data   (rd_data),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .rd_latch  (rd_latch),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b0; wait_cyc(2*Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(2*Q);
    sda_m = 1'b0; wait_cyc(2*Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(2*Q);
    sda_m = 1'b1; wait_cyc(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(2*Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    b = sda_line; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack);
    logic a;
    exp_rx.push_back({1'b1, 7'b0, exp_ack});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    obs_rx.push_back({1'b1, 7'b0, a});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic ack);
    logic [7:0] r;
    logic       b;
    exp_rx.push_back({1'b0, exp});
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      r[i] = b;
    end
    obs_rx.push_back({1'b0, r});
    send_bit(ack);
  endtask

  // Monitor: pops an expectation whenever the DUT or bus presents an event
  always @(negedge clk) begin : monitor
    logic [7:0] e8;
    logic [8:0] e9;
    logic [8:0] o9;
    if (!reset) begin
      if (cmd_valid) begin
        checks++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL cmd_valid: unexpected pulse, cmd_data=%h", cmd_data);
        end else begin
          e8 = exp_cmd.pop_front();
          if (cmd_data !== e8) begin
            errors++;
            $display("FAIL cmd_data: got %h, required %h", cmd_data, e8);
          end
        end
      end
      if (rd_latch) begin
        checks++;
        if (exp_latch.size() == 0) begin
          errors++;
          $display("FAIL rd_latch: unexpected pulse");
        end else begin
          void'(exp_latch.pop_front());
        end
      end
      while (obs_rx.size() > 0) begin
        o9 = obs_rx.pop_front();
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL bus_rx: unexpected observation %h", o9);
        end else begin
          e9 = exp_rx.pop_front();
          if (o9 !== e9) begin
            errors++;
            $display("FAIL bus_rx: got %h, required %h (bit8 set = ack slot)", o9, e9);
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete within cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int waited;
    wait_cyc(5);
    check("reset_sda_dir", 16'(sda_dir), 16'h0);
    check("reset_sda_out", 16'(sda_out), 16'h1);
    check("reset_cmd_data", 16'(cmd_data), 16'h00);
    check("reset_cmd_valid", 16'(cmd_valid), 16'h0);
    check("reset_rd_latch", 16'(rd_latch), 16'h0);
    check("reset_busy", 16'(busy), 16'h0);
    reset = 1'b0;
    wait_cyc(20);

    // 1: write command 0x01
    bus_start();
    write_byte(8'h46, ACK);
    check("t1_busy_after_ack", 16'(busy), 16'h1);
    exp_cmd.push_back(8'h01);
    write_byte(8'h01, ACK);
    bus_stop();
    check("t1_busy_after_stop", 16'(busy), 16'h0);
    check("t1_cmd_data", 16'(cmd_data), 16'h01);

    // 2: read 0x1234, ACK then NACK
    bus_start();
    exp_latch.push_back(1'b1);
    write_byte(8'h47, ACK);
    read_byte(8'h12, ACK);
    read_byte(8'h34, NACK);
    check("t2_busy_after_nack", 16'(busy), 16'h0);
    bus_stop();

    // 3: foreign address is NACKed and ignored
    bus_start();
    write_byte(8'h48, NACK);
    check("t3_busy", 16'(busy), 16'h0);
    write_byte(8'h55, NACK);
    check("t3_sda_dir", 16'(sda_dir), 16'h0);
    bus_stop();

    // 4: write, repeated START, read past the payload
    bus_start();
    write_byte(8'h46, ACK);
    exp_cmd.push_back(8'h10);
    write_byte(8'h10, ACK);
    bus_rstart();
    exp_latch.push_back(1'b1);
    write_byte(8'h47, ACK);
    read_byte(8'h12, ACK);
    read_byte(8'h34, ACK);
    read_byte(8'hFF, ACK);
    read_byte(8'hFF, NACK);
    bus_stop();
    check("t4_cmd_data", 16'(cmd_data), 16'h10);

    // 5: snapshot holds through a mid-read rd_data change
    bus_start();
    exp_latch.push_back(1'b1);
    write_byte(8'h47, ACK);
    read_byte(8'h12, ACK);
    rd_data = 16'hBEEF;
    read_byte(8'h34, NACK);
    bus_stop();
    bus_start();
    exp_latch.push_back(1'b1);
    write_byte(8'h47, ACK);
    read_byte(8'hBE, ACK);
    read_byte(8'hEF, NACK);
    bus_stop();

    // 6a: async reset while driving the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(logic'(8'h46 >> i));
    waited = 0;
    while (sda_dir !== 1'b1 && waited < 4*Q) begin
      wait_cyc(1);
      waited++;
    end
    check("t6_ack_driven", 16'(sda_dir), 16'h1);
    reset = 1'b1;
    #1;
    check("t6_reset_sda_dir", 16'(sda_dir), 16'h0);
    check("t6_reset_sda_out", 16'(sda_out), 16'h1);
    check("t6_reset_busy", 16'(busy), 16'h0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(20);

    // 6b: SCL glitch of FILT_LEN-1 cycles must not clock a bit
    bus_start();
    scl_m = 1'b1;
    wait_cyc(FILT_LEN - 1);
    scl_m = 1'b0;
    wait_cyc(Q);
    write_byte(8'h46, ACK);
    exp_cmd.push_back(8'hA5);
    write_byte(8'hA5, ACK);
    bus_stop();
    check("t6_cmd_data", 16'(cmd_data), 16'hA5);

    wait_cyc(5);
    check("end_exp_cmd_empty", 16'(exp_cmd.size()), 16'h0);
    check("end_exp_latch_empty", 16'(exp_latch.size()), 16'h0);
    check("end_exp_rx_empty", 16'(exp_rx.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
